// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch stage.
package cpu_pkg;

  typedef enum logic {RUN, FLUSH} fetch_state_t;

  localparam int INSTR_BYTES = 4;
  localparam logic [4:0] LINK_REG = 5'd30;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch target and BL link address generation for the ID-stage branch.
module branch_target_calc #(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              uncond_br,
  input  logic [18:0]       cond_addr19,
  input  logic [25:0]       br_addr26,
  output logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] link_addr
);
  import cpu_pkg::*;

  logic [ADDR_W-1:0] off19;
  logic [ADDR_W-1:0] off26;

  // Offsets count instructions, so scale by four after sign extension.
  assign off19 = {{(ADDR_W-21){cond_addr19[18]}}, cond_addr19, 2'b00};
  assign off26 = {{(ADDR_W-28){br_addr26[25]}}, br_addr26, 2'b00};

  assign br_target = id_pc + (uncond_br ? off26 : off19);
  assign link_addr = id_pc + ADDR_W'(INSTR_BYTES);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, next-PC selection and one-bubble redirect squash.
// Optional redirect counter output br_count enabled by `define PC_FETCH_BRCNT_EN.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              BrTaken,
  input  logic              UncondBr,
  input  logic              pc_rd,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [18:0]       cond_addr19,
  input  logic [25:0]       br_addr26,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc,
  output logic              if_id_flush,
  output logic [ADDR_W-1:0] link_addr
`ifdef PC_FETCH_BRCNT_EN
  ,
  output logic [31:0]       br_count
`endif
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] br_target;
  logic              redirect;

  branch_target_calc #(.ADDR_W(ADDR_W)) u_target (
    .id_pc      (id_pc),
    .uncond_br  (UncondBr),
    .cond_addr19(cond_addr19),
    .br_addr26  (br_addr26),
    .br_target  (br_target),
    .link_addr  (link_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else begin
      pc    <= pc_next;
      state <= state_next;
    end
  end

  // Branch inputs are only looked at in RUN; FLUSH steps past the squashed slot.
  always_comb begin
    pc_next    = pc;
    state_next = state;
    redirect   = 1'b0;
    unique case (state)
      RUN: begin
        if (!stall && !reset) begin
          if (pc_rd || BrTaken) begin
            redirect   = 1'b1;
            state_next = FLUSH;
            pc_next    = pc_rd ? reg_target : br_target;
          end else begin
            pc_next = pc + ADDR_W'(INSTR_BYTES);
          end
        end
      end
      FLUSH: begin
        if (!stall) begin
          state_next = RUN;
          pc_next    = pc + ADDR_W'(INSTR_BYTES);
        end
      end
    endcase
  end

  assign if_id_flush = redirect;

`ifdef PC_FETCH_BRCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count <= '0;
    end else if (redirect) begin
      br_count <= br_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: driver queues expected outputs, monitor checks each negedge.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        BrTaken;
  logic        UncondBr;
  logic        pc_rd;
  logic [63:0] id_pc;
  logic [18:0] cond_addr19;
  logic [25:0] br_addr26;
  logic [63:0] reg_target;
  logic [63:0] pc;
  logic        if_id_flush;
  logic [63:0] link_addr;
`ifdef PC_FETCH_BRCNT_EN
  logic [31:0] br_count;
`endif

  typedef struct {
    logic [63:0] pc;
    logic        flush;
    logic [63:0] link;
    logic        chk_link;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt = '0;

  pc_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .BrTaken    (BrTaken),
    .UncondBr   (UncondBr),
    .pc_rd      (pc_rd),
    .id_pc      (id_pc),
    .cond_addr19(cond_addr19),
    .br_addr26  (br_addr26),
    .reg_target (reg_target),
    .pc         (pc),
    .if_id_flush(if_id_flush),
    .link_addr  (link_addr)
`ifdef PC_FETCH_BRCNT_EN
    ,
    .br_count   (br_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle's inputs shortly after the edge and queues what that cycle must show.
  task automatic applyStimulus(
    input logic        rst, input logic stl, input logic br, input logic unc, input logic prd,
    input logic [63:0] idp, input logic [18:0] c19, input logic [25:0] b26, input logic [63:0] regt,
    input logic [63:0] e_pc, input logic e_flush, input logic [63:0] e_link, input logic e_chk_link);
    exp_t e;
    reset       = rst;
    stall       = stl;
    BrTaken     = br;
    UncondBr    = unc;
    pc_rd       = prd;
    id_pc       = idp;
    cond_addr19 = c19;
    br_addr26   = b26;
    reg_target  = regt;
    if (rst) exp_cnt = '0;
    e.pc       = e_pc;
    e.flush    = e_flush;
    e.link     = e_link;
    e.chk_link = e_chk_link;
    e.cnt      = exp_cnt;
    sb.push_back(e);
    if (e_flush) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("pc", pc, e.pc);
        checkOutput("if_id_flush", {63'd0, if_id_flush}, {63'd0, e.flush});
        if (e.chk_link) checkOutput("link_addr", link_addr, e.link);
`ifdef PC_FETCH_BRCNT_EN
        checkOutput("br_count", {32'd0, br_count}, {32'd0, e.cnt});
`endif
      end
    end
  end

  initial begin : driver
    int wait_cycles;
    reset = 1'b1; stall = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0; pc_rd = 1'b0;
    id_pc = '0; cond_addr19 = '0; br_addr26 = '0; reg_target = '0;
    @(posedge clk);
    @(posedge clk);
    #2;

    // Sequential fetch out of reset
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 0, 0, 0, 0, 64'h0, 19'd0, 26'd0, 64'h0, 64'(4 * i), 0, 64'h0, 0);

    // B with negative offset, then a taken branch in the squashed slot
    applyStimulus(0, 0, 1, 1, 0, 64'h40, 19'd0, 26'h3FFFFFE, 64'h0, 64'h14, 1, 64'h44, 1);
    applyStimulus(0, 0, 1, 1, 0, 64'h40, 19'd0, 26'h3FFFFFE, 64'h0, 64'h38, 0, 64'h44, 1);
    applyStimulus(0, 0, 0, 0, 0, 64'h0, 19'd0, 26'd0, 64'h0, 64'h3C, 0, 64'h0, 0);

    // CBZ taken, unknown branch inputs during FLUSH, then not taken
    applyStimulus(0, 0, 1, 0, 0, 64'h100, 19'd5, 26'd0, 64'h0, 64'h40, 1, 64'h104, 1);
    applyStimulus(0, 0, 1'bx, 0, 1'bx, 64'h100, 19'd5, 26'd0, 64'h0, 64'h114, 0, 64'h104, 1);
    applyStimulus(0, 0, 0, 0, 0, 64'h100, 19'd5, 26'd0, 64'h0, 64'h118, 0, 64'h104, 1);

    // BR wins over BrTaken
    applyStimulus(0, 0, 1, 1, 1, 64'h200, 19'd0, 26'h10, 64'h2000, 64'h11C, 1, 64'h204, 1);
    applyStimulus(0, 0, 0, 0, 0, 64'h0, 19'd0, 26'd0, 64'h0, 64'h2000, 0, 64'h0, 0);

    // Stall holds a pending branch, redirect on first unstalled cycle, stall holds FLUSH
    applyStimulus(0, 1, 1, 0, 0, 64'h300, 19'd2, 26'd0, 64'h0, 64'h2004, 0, 64'h304, 1);
    applyStimulus(0, 1, 1, 0, 0, 64'h300, 19'd2, 26'd0, 64'h0, 64'h2004, 0, 64'h304, 1);
    applyStimulus(0, 0, 1, 0, 0, 64'h300, 19'd2, 26'd0, 64'h0, 64'h2004, 1, 64'h304, 1);
    applyStimulus(0, 1, 1, 0, 0, 64'h300, 19'd2, 26'd0, 64'h0, 64'h308, 0, 64'h304, 1);
    applyStimulus(0, 0, 1, 0, 0, 64'h300, 19'd2, 26'd0, 64'h0, 64'h308, 0, 64'h304, 1);
    applyStimulus(0, 0, 0, 0, 0, 64'h0, 19'd0, 26'd0, 64'h0, 64'h30C, 0, 64'h0, 0);

    // Reset asserted mid-cycle while in FLUSH, then a branch proves the FSM is back in RUN
    applyStimulus(0, 0, 1, 1, 0, 64'h400, 19'd0, 26'd4, 64'h0, 64'h310, 1, 64'h404, 1);
    applyStimulus(1, 0, 1, 1, 0, 64'h400, 19'd0, 26'd4, 64'h0, 64'h0, 0, 64'h404, 1);
    applyStimulus(0, 0, 1, 1, 0, 64'h40, 19'd0, 26'h3FFFFFE, 64'h0, 64'h0, 1, 64'h44, 1);
    applyStimulus(0, 0, 0, 0, 0, 64'h0, 19'd0, 26'd0, 64'h0, 64'h38, 0, 64'h0, 0);

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
